apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts a simple single-outstanding valid/ready register-request interface from the CPU/interconnect side into APB transactions.
- Decodes the target among up to 16 APB slaves, drives the shared APB signals and one PSEL per slave, and returns read data plus an error flag.
- Sits directly upstream of the APB peripherals (apb_SIO and similar).

Parameters:
- NUM_SLAVES, 4: number of PSEL outputs (1..16).
- SLAVE_ADDR_BITS, 12: byte-address window per slave, 2^SLAVE_ADDR_BITS bytes each.
- BASE_ADDR, 32'h8000_0000: base of slave 0; must be aligned to 16 windows.
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles waiting for PREADY before an error response (1..255).

Ports:
- PCLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_error  out  1  decode miss or timeout.
- PADDR  out  SLAVE_ADDR_BITS  in-window address (slaves use the low bits they need, e.g. [3:0]).
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  32*NUM_SLAVES  slave n read data at bits [32n+31:32n].
- PREADY  in  NUM_SLAVES  per-slave ready; tie high for zero-wait slaves.

Behaviour:
- Decode:
  - idx = req_addr[SLAVE_ADDR_BITS+3:SLAVE_ADDR_BITS].
  - Hit iff req_addr[31:SLAVE_ADDR_BITS+4] == BASE_ADDR[31:SLAVE_ADDR_BITS+4] and idx < NUM_SLAVES; otherwise miss.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch write/addr/wdata/idx.
  - Hit -> SETUP. Miss -> RESP with rsp_error=1, rsp_rdata=0, no APB activity.
- SETUP:
  - PSEL[idx]=1, PENABLE=0. PADDR, PWRITE and PWDATA take the latched values.
  - Timeout counter cleared. Unconditionally -> ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1, address/data held stable.
  - If PREADY[idx]: capture PRDATA slice idx (reads only; writes capture 0), rsp_error=0 -> RESP.
  - Else the counter increments. When the counter reaches TIMEOUT_CYCLES with PREADY still low: rsp_error=1, rsp_rdata=0 -> RESP.
  - Exactly TIMEOUT_CYCLES ACCESS cycles are allowed; PREADY in the last of them still succeeds.
- RESP:
  - rsp_valid=1, rsp_rdata and rsp_error held. PSEL=0, PENABLE=0.
  - On rsp_ready -> IDLE.
- Handshakes:
  - req_ready=0 outside IDLE.
  - A request and a response are never transferred in the same cycle; one transaction is outstanding at a time.
  - Earliest next acceptance is the cycle after the rsp handshake.
  - rsp_valid is held until accepted, and rsp fields are stable while rsp_valid=1.
- Latency, zero-wait slave: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
- Decode-miss latency: rsp_valid on the cycle after acceptance.
- APB outputs:
  - PADDR, PWRITE and PWDATA are registered and change only on request acceptance.
  - PENABLE=1 only in ACCESS.
  - At most one PSEL bit is set at any time.
- Reset (RESET=1 at a clock edge): state=IDLE; rsp_valid=0, rsp_error=0, rsp_rdata=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter=0.
- Reset mid-transaction aborts immediately: PSEL and PENABLE are low on the next cycle, and no response is issued.
- Reset has priority over all other events.

Test Plan:
- Write to slave 0: addr 8000_0000, wdata 0000_00A5, PREADY all high. Required: SETUP at cycle 1 with PSEL=0001, PENABLE=0, PADDR=000, PWDATA=A5, PWRITE=1; PENABLE=1 at cycle 2; rsp_valid at cycle 3 with rsp_error=0 and rsp_rdata=0.
- Read from slave 2: addr 8000_200C, PRDATA slice 2 = DEAD_BEEF. Required: PSEL=0100, PADDR=00C, rsp_rdata=DEAD_BEEF.
- Decode miss: addr 8000_5000 (idx 5 ≥ 4), then addr 9000_0000. Required for each: rsp_error=1 on the next cycle and PSEL never asserted.
- Wait states: PREADY[1] low for 3 ACCESS cycles, then high. Required: ACCESS lasts 4 cycles with address/data stable throughout, then a good response. Repeat with TIMEOUT_CYCLES=4 and PREADY held low: after 4 ACCESS cycles, rsp_error=1 and PSEL drops.
- Backpressure: rsp_ready held low for 5 cycles. Required: rsp_valid, rsp_rdata and rsp_error stable and req_ready=0 throughout; back-to-back requests are accepted one per transaction.
- RESET asserted during ACCESS. Required: PSEL=0, PENABLE=0 and rsp_valid=0 next cycle, and req_ready=1 once RESET deasserts.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready request to APB master bridge.
//
// Decodes a 32-bit byte address into one of up to 16 APB slave windows. It then
// runs the APB SETUP/ACCESS sequence and returns read data plus an error flag.
// The error flag is set on a decode miss or on a PREADY timeout.
//
// Ports:
//   PCLK, RESET          clock (posedge) and synchronous active-high reset
//   req_valid/req_ready  request handshake; req_write, req_addr, req_wdata payload
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_error payload
//   PADDR, PWRITE,       shared APB outputs (registered, change only on accept)
//   PWDATA, PENABLE
//   PSEL                 one-hot slave select
//   PRDATA, PREADY       per-slave read data (32 bits each) and ready
module apb_master_bridge #(
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                       PCLK,
  input  logic                       RESET,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_error,
  output logic [SLAVE_ADDR_BITS-1:0] PADDR,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  localparam int unsigned TagLsb      = SLAVE_ADDR_BITS + 4;
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic                       pwrite_q, pwrite_d;
  logic [SLAVE_ADDR_BITS-1:0] paddr_q, paddr_d;
  logic [31:0]                pwdata_q, pwdata_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       err_q, err_d;

  // Address decode of the incoming request.
  logic [3:0] req_idx;
  logic       req_hit;
  assign req_idx = req_addr[TagLsb-1:SLAVE_ADDR_BITS];
  assign req_hit = (req_addr[31:TagLsb] == BASE_ADDR[31:TagLsb]) &&
                   ({1'b0, req_idx} < 5'(NUM_SLAVES));

  // Selected-slave mux, written as a loop so idx never indexes past NUM_SLAVES.
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic [31:0]           sel_rdata;
  logic                  sel_ready;
  always_comb begin
    sel_onehot = '0;
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_rdata     = PRDATA[32*i +: 32];
        sel_ready     = PREADY[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          pwrite_d = req_write;
          paddr_d  = req_addr[SLAVE_ADDR_BITS-1:0];
          pwdata_d = req_wdata;
          idx_d    = req_idx;
          if (req_hit) begin
            state_d = StSetup;
          end else begin
            // Decode miss: answer directly, no APB cycle.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (sel_ready) begin
          rdata_d = pwrite_q ? 32'h0 : sel_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          // This was the last permitted ACCESS cycle.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PENABLE   = (state_q == StAccess);
  assign PSEL      = ((state_q == StSetup) || (state_q == StAccess)) ? sel_onehot : '0;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed cycle checks plus a randomized run.
// Expected responses go into a scoreboard queue when a request is issued. A
// separate monitor pops and compares them on each response handshake.
module tb_apb_master_bridge;

  localparam int NS      = 4;
  localparam int SAB     = 12;
  localparam int TIMEOUT = 4;

  logic              PCLK = 1'b0;
  logic              RESET;
  logic              req_valid, req_ready, req_write;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_ready, rsp_error;
  logic [31:0]       rsp_rdata;
  logic [SAB-1:0]    PADDR;
  logic              PWRITE, PENABLE;
  logic [31:0]       PWDATA;
  logic [NS-1:0]     PSEL;
  logic [32*NS-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;

  apb_master_bridge #(
    .NUM_SLAVES(NS), .SLAVE_ADDR_BITS(SAB), .BASE_ADDR(32'h8000_0000),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int s, input int w);
    if (s == 2 && w == 3) return 32'hDEAD_BEEF;
    return {8'hA0 + 8'(s), 8'(w), 16'h5A5A};
  endfunction

  // ---------------- APB slave model ----------------
  // wait_cfg = number of ACCESS cycles with PREADY low before it goes high.
  int          wait_cfg = 0;
  int          acc_cnt;
  logic [31:0] mem [NS][16];

  for (genvar g = 0; g < NS; g++) begin : g_slv
    assign PREADY[g]          = (wait_cfg == 0) ? 1'b1 : (PSEL[g] && (acc_cnt >= wait_cfg));
    assign PRDATA[32*g +: 32] = mem[g][PADDR[5:2]];
  end

  always @(posedge PCLK) begin
    if (RESET) begin
      acc_cnt <= 0;
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 16; w++) mem[s][w] <= init_val(s, w);
    end else if (PENABLE && (|PSEL)) begin
      if (|(PSEL & PREADY)) begin
        acc_cnt <= 0;
        for (int s = 0; s < NS; s++)
          if (PSEL[s] && PWRITE) mem[s][PADDR[5:2]] <= PWDATA;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [NS][16];

  task automatic ref_init();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 16; w++) ref_mem[s][w] = init_val(s, w);
  endtask

  // rsp_ready: random or forced, driven just after each rising edge.
  bit rr_rand  = 0;
  bit rr_force = 1;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge PCLK); #1;
      rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
    end
  end

  // Issue one request; returns just after the accepting clock edge.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int wc);
    exp_t e;
    int   idx;
    bit   hit;
    int   n;
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (req_ready) break;
      n++;
      if (n > 200) begin chk("req_accept_timeout", 0, 1); break; end
    end
    wait_cfg = wc;  // bridge is idle here, so no transfer is in flight
    idx = int'(a[15:12]);
    hit = (a[31:16] == 16'h8000) && (idx < NS);
    e.err   = !hit || (wc >= TIMEOUT);
    e.rdata = (e.err || w) ? 32'h0 : ref_mem[idx][a[5:2]];
    if (!e.err && w) ref_mem[idx][a[5:2]] = d;
    sb.push_back(e);
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    req_addr  = $urandom; req_wdata = $urandom; req_write = 1'($urandom_range(0, 1));
  endtask

  // ---------------- monitor ----------------
  bit          hold = 0;
  logic [31:0] h_rdata;
  logic        h_err;
  logic [SAB-1:0] s_addr;
  logic [31:0]    s_wdata;
  logic           s_write;
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (RESET) begin
        hold = 0;
      end else begin
        chk("psel_onehot0", 64'($onehot0(PSEL)), 1);
        if (|PSEL && !PENABLE) begin
          s_addr = PADDR; s_wdata = PWDATA; s_write = PWRITE;
        end
        if (PENABLE) begin
          chk("penable_has_psel", 64'(|PSEL), 1);
          chk("access_stable", {PADDR, PWDATA, PWRITE}, {s_addr, s_wdata, s_write});
        end
        if (rsp_valid) begin
          chk("req_ready_while_rsp", req_ready, 0);
          if (hold) chk("rsp_stable", {rsp_rdata, rsp_error}, {h_rdata, h_err});
          if (rsp_ready) begin
            hold = 0;
            if (sb.size() == 0) begin
              chk("unexpected_rsp", 0, 1);
            end else begin
              e = sb.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_error", rsp_error, e.err);
            end
          end else begin
            hold = 1; h_rdata = rsp_rdata; h_err = rsp_error;
          end
        end else begin
          hold = 0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    ref_init();
    repeat (3) @(negedge PCLK);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    @(posedge PCLK); #1; RESET = 1'b0;

    // Write to slave 0, zero wait.
    do_req(1'b1, 32'h8000_0000, 32'h0000_00A5, 0);
    @(negedge PCLK);
    chk("wr_setup_psel", PSEL, 4'b0001);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_paddr", PADDR, 12'h000);
    chk("wr_setup_pwdata", PWDATA, 32'hA5);
    chk("wr_setup_pwrite", PWRITE, 1);
    @(negedge PCLK);
    chk("wr_access_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_error", rsp_error, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);

    // Read from slave 2.
    do_req(1'b0, 32'h8000_200C, 32'h0, 0);
    @(negedge PCLK);
    chk("rd_psel", PSEL, 4'b0100);
    chk("rd_paddr", PADDR, 12'h00C);
    chk("rd_pwrite", PWRITE, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Decode misses.
    do_req(1'b0, 32'h8000_5000, 32'h0, 0);
    @(negedge PCLK);
    chk("miss1_rsp_valid", rsp_valid, 1);
    chk("miss1_rsp_error", rsp_error, 1);
    chk("miss1_psel", PSEL, 0);
    do_req(1'b1, 32'h9000_0000, 32'h1234, 0);
    @(negedge PCLK);
    chk("miss2_rsp_valid", rsp_valid, 1);
    chk("miss2_rsp_error", rsp_error, 1);
    chk("miss2_psel", PSEL, 0);

    // Three wait states on slave 1: ACCESS lasts 4 cycles, the last allowed.
    do_req(1'b0, 32'h8000_1008, 32'h0, 3);
    @(negedge PCLK);
    chk("ws_setup_psel", PSEL, 4'b0010);
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      chk("ws_access_penable", PENABLE, 1);
      chk("ws_access_psel", PSEL, 4'b0010);
      chk("ws_access_paddr", PADDR, 12'h008);
    end
    @(negedge PCLK);
    chk("ws_rsp_valid", rsp_valid, 1);
    chk("ws_rsp_error", rsp_error, 0);

    // PREADY held low: error after exactly 4 ACCESS cycles.
    do_req(1'b1, 32'h8000_1010, 32'hCAFE_0001, 100);
    @(negedge PCLK);
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      chk("to_access_penable", PENABLE, 1);
    end
    @(negedge PCLK);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_psel_dropped", PSEL, 0);

    // Backpressure: rsp_ready low for 5 cycles.
    rr_force = 0;
    do_req(1'b0, 32'h8000_3004, 32'h0, 0);
    @(negedge PCLK); @(negedge PCLK);
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    rr_force = 1;
    do_req(1'b1, 32'h8000_3004, 32'h1111_2222, 0);
    do_req(1'b0, 32'h8000_3004, 32'h0, 0);

    // Reset during ACCESS.
    do_req(1'b0, 32'h8000_3008, 32'h0, 10);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid_access", PENABLE, 1);
    @(posedge PCLK); #1; RESET = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    sb.delete();
    ref_init();
    @(posedge PCLK); #1; RESET = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_req_ready", req_ready, 1);

    // Randomized traffic.
    rr_rand = 1;
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 99);
      if (k < 70)      a = 32'h8000_0000 | ($urandom_range(0, NS - 1) << 12) | ($urandom & 32'hFFC);
      else if (k < 85) a = 32'h8000_0000 | ($urandom_range(NS, 15) << 12) | ($urandom & 32'hFFC);
      else             a = $urandom;
      do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 5));
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge PCLK); n++; end
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
